// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then releases the system reset.
// Define PLL_RESET_SEQUENCER_LOSS_CNT_EN to add the 8-bit lock_loss_cnt output.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [2:0] state_dbg
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // The counter holds "cycles remaining minus one", so zero marks the last cycle of a phase.
  localparam logic [CW-1:0] RST_LOAD  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STAB_LOAD = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_RST_PLL   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    retry_d;
  logic [2:0]    retry_inc;
  logic          sync_q1;
  logic          lock_s;
  logic          pll_rst_d;
  logic          sys_rst_d;
  logic          ready_d;
  logic          fail_d;

  // Two-flop synchronizer; lock_s is the only form of the lock input the FSM sees.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      lock_s  <= sync_q1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RST_PLL;
      cnt_q     <= RST_LOAD;
      retry_cnt <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
    end
  end

  assign retry_inc = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    case (state_q)
      S_RST_PLL: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring on the same cycle.
        if (lock_s) begin
          state_d = S_STABILIZE;
          cnt_d   = STAB_LOAD;
        end else if (cnt_q == '0) begin
          retry_d = retry_inc;
          if (int'(retry_inc) == MAX_RETRIES) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RST_PLL;
            cnt_d   = RST_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STABILIZE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = WAIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          retry_d = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RST_PLL;
          cnt_d   = RST_LOAD;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RST_PLL;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // Outputs decode the next state and are registered, so they line up with state_q.
  always_comb begin
    pll_rst_d = 1'b0;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      S_RST_PLL: pll_rst_d = 1'b1;
      S_RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      S_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      pll_rst <= pll_rst_d;
      sys_rst <= sys_rst_d;
      ready   <= ready_d;
      fail    <= fail_d;
    end
  end

  assign state_dbg = state_q;

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  logic loss_event;

  assign loss_event = (state_q == S_RUN) && !lock_s;

  // Counts RUN exits due to lock loss; cleared only by rst.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_event && (lock_loss_cnt != 8'd255)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held high per reset attempt (min 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, max cycles waiting for lock per attempt.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 4, lock-timeout attempts allowed before FAIL (min 1).
REQ-005 refclk  in  1  sole clock, 50 MHz board reference; all logic on rising edge; one clock, no other clock domain.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pll_locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-008 pll_rst  out  1  reset drive to the PLL, active-high.
REQ-009 sys_rst  out  1  reset for logic clocked by the PLL output, active-high.
REQ-010 ready  out  1  high only in RUN.
REQ-011 fail  out  1  high only in FAIL.
REQ-012 retry_cnt  out  3  timeouts since last RUN entry, saturating at 7.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; "lock_s" below is the second flop output; no logic reads pll_locked directly.
REQ-014 States SHALL be RST_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL; one down-counter shared by RST_PLL, WAIT_LOCK and STABILIZE, reloaded on every state entry.
REQ-015 RST_PLL: pll_rst=1, sys_rst=1; SHALL last exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, sys_rst=1; lock_s=1 -> STABILIZE next edge; LOCK_TIMEOUT_CYCLES cycles with lock_s=0 -> timeout.
REQ-017 On timeout retry_cnt SHALL increment; if new value equals MAX_RETRIES go to FAIL, else go to RST_PLL.
REQ-018 STABILIZE: pll_rst=0, sys_rst=1; lock_s=0 on any cycle -> WAIT_LOCK with timeout counter reloaded, no retry increment; LOCK_STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN.
REQ-019 RUN: pll_rst=0, sys_rst=0, ready=1; retry_cnt SHALL clear on RUN entry.
REQ-020 RUN with lock_s=0: SHALL go to RST_PLL next edge; sys_rst and pll_rst high from that edge (exactly one cycle after lock_s falls).
REQ-021 FAIL: pll_rst=1, sys_rst=1, fail=1; SHALL hold until rst.
REQ-022 Simultaneous lock_s rise and timeout expiry in WAIT_LOCK: lock wins (STABILIZE, no increment).
REQ-023 All outputs SHALL be registered; no combinational path from pll_locked to any output.

Reset
REQ-024 While rst=1: state RST_PLL with counter loaded, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, synchronizer flops 0, loss counter (if built) 0.
REQ-025 First cycle with rst=0 SHALL count as RST_PLL cycle 1; rst asserted mid-sequence (any state, incl. FAIL) SHALL restart from RST_PLL on the next edge.

Configuration
REQ-026 Macro PLL_RESET_SEQUENCER_LOSS_CNT_EN, when defined, SHALL add output lock_loss_cnt (8 bits) that increments on each RUN->RST_PLL transition, saturates at 255, clears only on rst.
REQ-027 Without PLL_RESET_SEQUENCER_LOSS_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification (bench params PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-028 Clean start: rst 3 cycles, pll_locked rises 10 cycles after rst release -> pll_rst high for cycles 1-4 after release; ready=1, sys_rst=0 exactly 2+8+1 cycles after pll_locked rises.
REQ-029 Glitch: pll_locked low for 3 cycles mid-STABILIZE -> stays in WAIT_LOCK/STABILIZE, retry_cnt=0, RUN reached 8 cycles of lock_s after lock returns.
REQ-030 Lock loss in RUN: pll_locked falls -> sys_rst=1 and pll_rst=1 3 edges later, ready=0, lock_loss_cnt=1 (macro defined); re-lock returns to RUN.
REQ-031 No lock ever -> retry_cnt 1 after first timeout, fail=1 with retry_cnt=2 after second; pll_rst stays 1 for 100 further cycles.
REQ-032 rst pulse in FAIL -> fail=0, retry_cnt=0, fresh 4-cycle pll_rst; lock then reaches RUN.
REQ-033 Build without macro -> lock_loss_cnt absent; REQ-028 to REQ-032 timing identical.
